// File: rtl/cpu_ctrl_pkg.sv
// Shared opcode constants, FSM state encoding and strobe bundle for the DataPath control sequencer.
package cpu_ctrl_pkg;

  localparam logic [4:0] OpLd     = 5'b00000;
  localparam logic [4:0] OpLdi    = 5'b00001;
  localparam logic [4:0] OpSt     = 5'b00010;
  localparam logic [4:0] OpAdd    = 5'b00011;
  localparam logic [4:0] OpRLast  = 5'b01011;
  localparam logic [4:0] OpAddi   = 5'b01100;
  localparam logic [4:0] OpOri    = 5'b01110;
  localparam logic [4:0] OpDiv    = 5'b01111;
  localparam logic [4:0] OpMul    = 5'b10000;
  localparam logic [4:0] OpNeg    = 5'b10001;
  localparam logic [4:0] OpNot    = 5'b10010;
  localparam logic [4:0] OpBr     = 5'b10011;
  localparam logic [4:0] OpJal    = 5'b10100;
  localparam logic [4:0] OpJr     = 5'b10101;
  localparam logic [4:0] OpIn     = 5'b10110;
  localparam logic [4:0] OpOut    = 5'b10111;
  localparam logic [4:0] OpMflo   = 5'b11000;
  localparam logic [4:0] OpMfhi   = 5'b11001;
  localparam logic [4:0] OpNop    = 5'b11010;
  localparam logic [4:0] OpHalt   = 5'b11011;

  typedef enum logic [3:0] {T0, T1, T2, T3, T4, T5, T6, T7, HALT} state_e;

  typedef enum logic [3:0] {
    ClsLdi, ClsLd, ClsSt, ClsAlu, ClsImm, ClsMulDiv, ClsUnary, ClsBr,
    ClsJr, ClsIn, ClsOut, ClsMflo, ClsMfhi, ClsNone, ClsHalt
  } cls_e;

  typedef struct packed {
    logic pc_out, zhigh_out, zlow_out, mdr_out, hi_out, lo_out, in_port_out, c_out, ba_out, r_out;
    logic mar_in, pc_in, mdr_in, ir_in, y_in, zlow_in, zhigh_in, hi_in, lo_in, r_in, con_in;
    logic out_port_in, inc_pc, read, write, gra, grb, grc;
  } strobes_t;

  function automatic cls_e op_class(input logic [4:0] op);
    if (op == OpLd) return ClsLd;
    if (op == OpLdi) return ClsLdi;
    if (op == OpSt) return ClsSt;
    if (op >= OpAdd && op <= OpRLast) return ClsAlu;
    if (op >= OpAddi && op <= OpOri) return ClsImm;
    if (op == OpDiv || op == OpMul) return ClsMulDiv;
    if (op == OpNeg || op == OpNot) return ClsUnary;
    if (op == OpBr) return ClsBr;
    if (op == OpJr) return ClsJr;
    if (op == OpIn) return ClsIn;
    if (op == OpOut) return ClsOut;
    if (op == OpMflo) return ClsMflo;
    if (op == OpMfhi) return ClsMfhi;
    if (op == OpHalt) return ClsHalt;
    return ClsNone;  // nop, jal and undefined opcodes
  endfunction

  function automatic state_e last_step(input cls_e cls);
    case (cls)
      ClsLdi, ClsAlu, ClsImm: return T5;
      ClsLd, ClsSt:           return T7;
      ClsMulDiv, ClsBr:       return T6;
      ClsUnary:               return T4;
      default:                return T3;
    endcase
  endfunction

endpackage

// File: rtl/control_sequencer.sv
// Moore control sequencer for DataPath: fetch T0-T2, opcode decode, execute T3-T7, halt/stop.
module control_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter logic [4:0] ADD_OP    = 5'b00011,
  parameter bit         RESET_RUN = 1'b1
) (
  input  logic        clock,
  input  logic        clear,
  input  logic [31:0] ir,
  input  logic        con_ff,
  input  logic        mem_ready,
  input  logic        stop,
  output logic        run,
  output logic        PCout,
  output logic        Zhighout,
  output logic        Zlowout,
  output logic        MDRout,
  output logic        HIout,
  output logic        LOout,
  output logic        InPortout,
  output logic        Cout,
  output logic        BAout,
  output logic        Rout,
  output logic        MARin,
  output logic        PCin,
  output logic        MDRin,
  output logic        IRin,
  output logic        Yin,
  output logic        ZLowIn,
  output logic        ZHighIn,
  output logic        HIin,
  output logic        LOin,
  output logic        Rin,
  output logic        CONin,
  output logic        OutPortin,
  output logic        IncPC,
  output logic        Read,
  output logic        Write,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic [4:0]  opcode
);

  state_e   state_q, state_d, last, ret;
  logic     stop_q, run_q, mem_wait;
  cls_e     cls;
  strobes_t s;
  logic     unused_ir;

  // Only the opcode field steers sequencing; the rest of IR belongs to DataPath.
  assign unused_ir = ^ir[26:0];

  assign cls  = op_class(ir[31:27]);
  assign last = last_step(cls);

  // run_q is low for the reset cycle(s) so strobes stay quiet while state already sits at T0.
  always_ff @(posedge clock) begin
    if (!clear) begin
      state_q <= T0;
      stop_q  <= 1'b0;
      run_q   <= 1'b0;
    end else begin
      run_q  <= RESET_RUN;
      stop_q <= stop_q | stop;
      if (run_q) state_q <= state_d;
    end
  end

  always_comb begin
    ret      = (stop_q || stop) ? HALT : T0;
    mem_wait = (state_q == T1) || (state_q == T6 && cls == ClsLd) ||
               (state_q == T7 && cls == ClsSt);
    state_d  = state_q;
    if (!mem_wait || mem_ready) begin
      unique case (state_q)
        T0:     state_d = T1;
        T1:     state_d = T2;
        T2:     state_d = T3;
        T3:     state_d = (cls == ClsHalt) ? HALT : (last == T3) ? ret : T4;
        T4, T5, T6, T7: state_d = (state_q == last) ? ret : state_e'(state_q + 4'd1);
        HALT:   state_d = HALT;
        default: state_d = T0;
      endcase
    end
  end

  always_comb begin
    s      = '0;
    opcode = 5'b00000;
    if (run_q) begin
      unique case (state_q)
        T0: begin s.pc_out = 1'b1; s.mar_in = 1'b1; s.inc_pc = 1'b1; s.zlow_in = 1'b1; end
        T1: begin s.zlow_out = 1'b1; s.pc_in = 1'b1; s.read = 1'b1; s.mdr_in = 1'b1; end
        T2: begin s.mdr_out = 1'b1; s.ir_in = 1'b1; end
        T3: begin
          case (cls)
            ClsLdi, ClsLd, ClsSt: begin s.grb = 1'b1; s.ba_out = 1'b1; s.y_in = 1'b1; end
            ClsAlu, ClsImm:       begin s.grb = 1'b1; s.r_out = 1'b1; s.y_in = 1'b1; end
            ClsMulDiv:            begin s.gra = 1'b1; s.r_out = 1'b1; s.y_in = 1'b1; end
            ClsUnary: begin
              s.grb = 1'b1; s.r_out = 1'b1; s.zlow_in = 1'b1; opcode = ir[31:27];
            end
            ClsBr:   begin s.gra = 1'b1; s.r_out = 1'b1; s.con_in = 1'b1; end
            ClsJr:   begin s.gra = 1'b1; s.r_out = 1'b1; s.pc_in = 1'b1; end
            ClsIn:   begin s.in_port_out = 1'b1; s.gra = 1'b1; s.r_in = 1'b1; end
            ClsOut:  begin s.gra = 1'b1; s.r_out = 1'b1; s.out_port_in = 1'b1; end
            ClsMflo: begin s.lo_out = 1'b1; s.gra = 1'b1; s.r_in = 1'b1; end
            ClsMfhi: begin s.hi_out = 1'b1; s.gra = 1'b1; s.r_in = 1'b1; end
            default: ;
          endcase
        end
        T4: begin
          case (cls)
            ClsLdi, ClsLd, ClsSt: begin s.c_out = 1'b1; s.zlow_in = 1'b1; opcode = ADD_OP; end
            ClsAlu: begin
              s.grc = 1'b1; s.r_out = 1'b1; s.zlow_in = 1'b1; opcode = ir[31:27];
            end
            ClsImm: begin s.c_out = 1'b1; s.zlow_in = 1'b1; opcode = ir[31:27]; end
            ClsMulDiv: begin
              s.grb = 1'b1; s.r_out = 1'b1; s.zlow_in = 1'b1; s.zhigh_in = 1'b1;
              opcode = ir[31:27];
            end
            ClsUnary: begin s.zlow_out = 1'b1; s.gra = 1'b1; s.r_in = 1'b1; end
            ClsBr:    begin s.pc_out = 1'b1; s.y_in = 1'b1; end
            default: ;
          endcase
        end
        T5: begin
          case (cls)
            ClsLdi, ClsAlu, ClsImm: begin s.zlow_out = 1'b1; s.gra = 1'b1; s.r_in = 1'b1; end
            ClsLd, ClsSt: begin s.zlow_out = 1'b1; s.mar_in = 1'b1; end
            ClsMulDiv:    begin s.zlow_out = 1'b1; s.lo_in = 1'b1; end
            ClsBr:        begin s.c_out = 1'b1; s.zlow_in = 1'b1; opcode = ADD_OP; end
            default: ;
          endcase
        end
        T6: begin
          case (cls)
            ClsLd:     begin s.read = 1'b1; s.mdr_in = 1'b1; end
            ClsSt:     begin s.gra = 1'b1; s.r_out = 1'b1; s.mdr_in = 1'b1; end
            ClsMulDiv: begin s.zhigh_out = 1'b1; s.hi_in = 1'b1; end
            ClsBr:     begin s.zlow_out = con_ff; s.pc_in = con_ff; end
            default: ;
          endcase
        end
        T7: begin
          case (cls)
            ClsLd:   begin s.mdr_out = 1'b1; s.gra = 1'b1; s.r_in = 1'b1; end
            ClsSt:   s.write = 1'b1;
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

  assign run       = run_q && (state_q != HALT);
  assign PCout     = s.pc_out;
  assign Zhighout  = s.zhigh_out;
  assign Zlowout   = s.zlow_out;
  assign MDRout    = s.mdr_out;
  assign HIout     = s.hi_out;
  assign LOout     = s.lo_out;
  assign InPortout = s.in_port_out;
  assign Cout      = s.c_out;
  assign BAout     = s.ba_out;
  assign Rout      = s.r_out;
  assign MARin     = s.mar_in;
  assign PCin      = s.pc_in;
  assign MDRin     = s.mdr_in;
  assign IRin      = s.ir_in;
  assign Yin       = s.y_in;
  assign ZLowIn    = s.zlow_in;
  assign ZHighIn   = s.zhigh_in;
  assign HIin      = s.hi_in;
  assign LOin      = s.lo_in;
  assign Rin       = s.r_in;
  assign CONin     = s.con_in;
  assign OutPortin = s.out_port_in;
  assign IncPC     = s.inc_pc;
  assign Read      = s.read;
  assign Write     = s.write;
  assign Gra       = s.gra;
  assign Grb       = s.grb;
  assign Grc       = s.grc;

endmodule
